// File: rtl/pwm_bank.sv
// Multi-channel PWM: one shared edge/centre-aligned counter, double-buffered period/mode/duty.
// Outputs are registered one cycle behind the counter; there is no backpressure, and load is always accepted.
module pwm_bank #(
    parameter int WIDTH    = 10,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [WIDTH-1:0]          period,
    input  logic                      center,
    input  logic [CHANNELS*WIDTH-1:0] duty,
    input  logic                      load,
    output logic [CHANNELS-1:0]       pwm,
    output logic                      period_start,
    output logic                      loaded
);

    typedef enum logic {UP, DOWN} dir_t;

    dir_t                      dir;
    logic [WIDTH-1:0]          count;
    logic [WIDTH-1:0]          per_q;
    logic [WIDTH-1:0]          stg_per;
    logic                      center_q;
    logic                      stg_center;
    logic [CHANNELS*WIDTH-1:0] duty_q;
    logic [CHANNELS*WIDTH-1:0] stg_duty;
    logic                      pending;
    logic                      boundary;
    logic                      xfer;
    logic [CHANNELS-1:0]       cmp;

    // Centre mode with a top of 0 or 1 never enters DOWN, so it ends its period like edge mode.
    always_comb begin
        boundary = 1'b0;
        if (!center_q || per_q <= WIDTH'(1))
            boundary = (count == per_q);
        else
            boundary = (dir == DOWN) && (count == WIDTH'(1));
        xfer = pending & (~en | boundary);
        for (int i = 0; i < CHANNELS; i++)
            cmp[i] = duty_q[i*WIDTH +: WIDTH] > count;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            dir   <= UP;
        end else if (!en || boundary) begin
            count <= '0;
            dir   <= UP;
        end else if (center_q && dir == UP && count == per_q) begin
            count <= count - WIDTH'(1);
            dir   <= DOWN;
        end else if (dir == DOWN) begin
            count <= count - WIDTH'(1);
        end else begin
            count <= count + WIDTH'(1);
        end
    end

    // A load coinciding with a transfer is staged behind it and stays pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_per    <= '0;
            stg_center <= 1'b0;
            stg_duty   <= '0;
            per_q      <= '0;
            center_q   <= 1'b0;
            duty_q     <= '0;
            pending    <= 1'b0;
        end else begin
            if (load) begin
                stg_per    <= period;
                stg_center <= center;
                stg_duty   <= duty;
            end
            if (xfer) begin
                per_q    <= stg_per;
                center_q <= stg_center;
                duty_q   <= stg_duty;
            end
            pending <= load | (pending & ~xfer);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm          <= '0;
            period_start <= 1'b0;
            loaded       <= 1'b0;
        end else begin
            pwm          <= en ? cmp : '0;
            period_start <= en & (count == '0);
            loaded       <= xfer;
        end
    end

endmodule
